stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: synchronized and debounced start/lap buttons drive an IDLE/RUN/LAP/STOP FSM plus a tick prescaler.
// A raw press changes state DEBOUNCE_CYCLES+3 cycles later; all outputs are registered and there is no backpressure.
module stopwatch_ctrl #(
    parameter int TICK_DIV        = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_lap,
    output logic       tick,
    output logic       clr,
    output logic       hold,
    output logic       running,
    output logic [1:0] state
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        LAP  = 2'b10,
        STOP = 2'b11
    } state_t;

    // Bit 0 is the start button, bit 1 the lap button.
    logic [1:0]    sync1, sync2, acc, acc_q, press;
    logic [DW-1:0] db_cnt [2];
    logic [PW-1:0] presc;
    state_t        cur, nxt;
    logic          clr_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            acc   <= '0;
            acc_q <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= {btn_lap, btn_start};
            sync2 <= sync1;
            acc_q <= acc;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == acc[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    acc[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = acc & ~acc_q;

    // Start has priority: a coincident lap event is simply dropped.
    always_comb begin
        nxt     = cur;
        clr_req = 1'b0;
        if (press[0]) begin
            nxt = (cur == RUN || cur == LAP) ? STOP : RUN;
        end else if (press[1]) begin
            case (cur)
                IDLE:    clr_req = 1'b1;
                RUN:     nxt = LAP;
                LAP:     nxt = RUN;
                STOP: begin
                    nxt     = IDLE;
                    clr_req = 1'b1;
                end
                default: nxt = IDLE;
            endcase
        end
    end

    // The prescaler follows the current state, so a wrap on the edge that
    // leaves RUN/LAP still produces its tick and a stopped count resumes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur     <= IDLE;
            hold    <= 1'b0;
            running <= 1'b0;
            clr     <= 1'b0;
            tick    <= 1'b0;
            presc   <= '0;
        end else begin
            cur     <= nxt;
            hold    <= (nxt == LAP);
            running <= (nxt == RUN) || (nxt == LAP);
            clr     <= clr_req;
            tick    <= running && (presc == PRESC_MAX);
            if (clr_req) begin
                presc <= '0;
            end else if (running) begin
                presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
            end
        end
    end

    assign state = cur;
endmodule
